// File: rtl/mips_cpu_muldiv_iter.sv
// Iterative MIPS HI/LO unit: shift-add multiply and restoring divide, one step per cycle,
// followed by a single sign-fixup cycle that writes HI/LO.
module mips_cpu_muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             dbz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  // state   | meaning
  // IDLE    | no operation in flight; accepts start
  // RUN     | WIDTH iteration steps (shift-add or restoring divide)
  // FIX     | sign correction and HI/LO write, done/dbz pulse follows
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [1:0]         state;
  logic [CW-1:0]      count;
  logic               is_div;
  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH:0]     rem;

  logic               op_iter;
  logic               op_signed;
  logic               op_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_shift;
  logic [WIDTH+1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op_iter   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_div    = (op == OP_DIV) || (op == OP_DIVU);

  // Magnitudes are unsigned, so the most negative value keeps its bit pattern.
  assign a_neg = op_signed & a[WIDTH-1];
  assign b_neg = op_signed & b[WIDTH-1];
  assign abs_a = a_neg ? -a : a;
  assign abs_b = b_neg ? -b : b;

  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mag_b[0] ? {1'b0, mag_a} : '0);

  // Dividend bits stream out of mag_a MSB-first; quotient bits shift into acc[WIDTH-1:0].
  assign div_shift = {rem, mag_a[WIDTH-1]};
  assign div_diff  = div_shift - {2'b00, mag_b};
  assign div_ge    = ~div_diff[WIDTH+1];

  assign prod_fix = (sa ^ sb) ? -acc : acc;
  assign quo_fix  = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = sa ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      count  <= '0;
      is_div <= 1'b0;
      sa     <= 1'b0;
      sb     <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      rem    <= '0;
      done   <= 1'b0;
      dbz    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      dbz  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (op_iter) begin
              sa     <= a_neg;
              sb     <= b_neg;
              mag_a  <= abs_a;
              mag_b  <= abs_b;
              is_div <= op_div;
              acc    <= '0;
              rem    <= '0;
              count  <= '0;
              state  <= ST_RUN;
            end else if (op == OP_MTHI) begin
              hi <= a;
            end else if (op == OP_MTLO) begin
              lo <= a;
            end
          end
        end
        ST_RUN: begin
          count <= count + CW'(1);
          if (is_div) begin
            rem             <= div_ge ? div_diff[WIDTH:0] : div_shift[WIDTH:0];
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ge};
            mag_a           <= mag_a << 1;
          end else begin
            acc   <= {mul_sum, acc[WIDTH-1:1]};
            mag_b <= mag_b >> 1;
          end
          if (count == LAST_STEP) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (is_div) begin
            // mag_b is untouched by the divide path, so it still holds |divisor|.
            if (mag_b == '0) begin
              dbz <= 1'b1;
            end else begin
              hi <= rem_fix;
              lo <= quo_fix;
            end
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_cpu_muldiv_iter.sv
// Scoreboard bench for mips_cpu_muldiv_iter: issued ops push expected HI/LO/dbz,
// a negedge monitor pops and compares on every done pulse.
module tb_mips_cpu_muldiv_iter;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } want_t;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic         dbz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    busy_end = -100;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  want_t sb_q[$];
  want_t mon_w;

  mips_cpu_muldiv_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .dbz(dbz), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  // Reference results straight from MIPS arithmetic on 64-bit integers.
  function automatic want_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    want_t       w;
    logic [63:0] p;
    longint      sx, sy, q, r;
    w.hi = m_hi; w.lo = m_lo; w.dbz = 1'b0;
    case (o)
      3'd1: begin
        p = longint'($signed(x)) * longint'($signed(y));
        w.hi = p[63:32]; w.lo = p[31:0];
      end
      3'd2: begin
        p = {32'b0, x} * {32'b0, y};
        w.hi = p[63:32]; w.lo = p[31:0];
      end
      3'd3, 3'd4: begin
        if (y == 0) begin
          w.dbz = 1'b1;
        end else begin
          sx = (o == 3'd3) ? longint'($signed(x)) : longint'({32'b0, x});
          sy = (o == 3'd3) ? longint'($signed(y)) : longint'({32'b0, y});
          q = sx / sy;
          r = sx % sy;
          w.lo = q[31:0]; w.hi = r[31:0];
        end
      end
      default: ;
    endcase
    return w;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit now = 1'b0);
    int    idx;
    bit    mt_acc;
    want_t w;
    mt_acc = 1'b0;
    if (!now) @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    idx = cyc;
    if (idx > busy_end) begin
      if (o >= 3'd1 && o <= 3'd4) begin
        w = model(o, x, y);
        sb_q.push_back(w);
        m_hi = w.hi; m_lo = w.lo;
        busy_end = idx + 33;
      end else if (o == 3'd5) begin
        m_hi = x; mt_acc = 1'b1;
      end else if (o == 3'd6) begin
        m_lo = x; mt_acc = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
    if (mt_acc) begin
      chk("mt_hi", hi, m_hi);
      chk("mt_lo", lo, m_lo);
      chk("mt_busy", busy, 0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", (n >= 200), 0);
  endtask

  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1, expected no pending op");
      end else begin
        mon_w = sb_q.pop_front();
        chk("done_hi", hi, mon_w.hi);
        chk("done_lo", lo, mon_w.lo);
        chk("done_dbz", dbz, mon_w.dbz);
      end
    end else if (dbz) begin
      checks++; errors++;
      $display("FAIL dbz_without_done: got dbz=1, expected 0");
    end
  end

  initial begin
    int busy_cnt, done_at, n, dn, r;
    logic [2:0]   o;
    logic [W-1:0] x, y;

    reset = 1'b0; start = 1'b0; op = 3'd0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_dbz", dbz, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Latency: busy for 33 samples, done on the 34th negedge after the accepting edge.
    issue(3'd1, 32'hFFFFFFFD, 32'd5);
    busy_cnt = busy ? 1 : 0;
    done_at = 0;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done && done_at == 0) done_at = k;
    end
    chk("busy_cycles", busy_cnt, 33);
    chk("done_latency", done_at, 34);
    chk("mult_hi_direct", hi, 32'hFFFFFFFF);
    chk("mult_lo_direct", lo, 32'hFFFFFFF1);

    issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_idle();
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_idle();
    issue(3'd3, 32'hFFFFFFF9, 32'd2);        wait_idle();
    issue(3'd4, 32'd100, 32'd7);             wait_idle();
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF); wait_idle();
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 0);

    issue(3'd5, 32'h1234, 32'd0);
    issue(3'd6, 32'h5678, 32'd0);
    issue(3'd4, 32'd9, 32'd0); wait_idle();
    chk("dbz_hi_kept", hi, 32'h1234);
    chk("dbz_lo_kept", lo, 32'h5678);

    // Starts while busy are dropped; a start in the done cycle is accepted.
    issue(3'd2, 32'd3, 32'd4);
    repeat (8) @(negedge clk);
    issue(3'd3, 32'd100, 32'd7);
    issue(3'd5, 32'hDEAD, 32'd0);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done_timeout", (n >= 100), 0);
    chk("ign_hi", hi, 0);
    chk("ign_lo", lo, 12);
    issue(3'd1, 32'd6, 32'hFFFFFFFE, 1'b1);
    wait_idle();

    for (int i = 0; i < 30; i++) begin
      o = 3'($urandom_range(1, 6));
      x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      r = $urandom_range(0, 4);
      case (r)
        0: y = 32'd0;
        1: y = 32'($urandom_range(1, 9));
        2: y = -32'($urandom_range(1, 9));
        default: y = $urandom;
      endcase
      issue(o, x, y);
      wait_idle();
    end

    // Asynchronous reset mid-operation discards it.
    issue(3'd5, 32'hAAAA, 32'd0);
    issue(3'd1, 32'd5, 32'd7);
    repeat (13) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_hi", hi, 0);
    chk("async_rst_lo", lo, 0);
    chk("async_rst_busy", busy, 0);
    sb_q.delete();
    m_hi = '0; m_lo = '0; busy_end = -100;
    @(negedge clk);
    reset = 1'b1;
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("no_done_after_rst", dn, 0);
    issue(3'd1, 32'd6, 32'd7); wait_idle();
    chk("post_rst_lo", lo, 42);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mips_cpu_muldiv_iter.md
Name: mips_cpu_muldiv_iter

Overview:
- Iterative multiply/divide unit sitting directly downstream of the ALU operand path.
- Consumes the rs/rt operand pair and the mult/div opcode in the EXEC state, computes a 64-bit product or a quotient/remainder over 32+1 cycles, and holds the results in HI/LO.
- The ALU result mux reads HI/LO for MFHI/MFLO.
- Exports busy so the control FSM stalls any HI/LO access until the operation completes.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request strobe, sampled on the rising edge.
- op  input  3  001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO; 000/111 no-op.
- a  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data).
- b  input  WIDTH  rt operand (multiplier / divisor).
- busy  output  1  high while an iterative operation is in flight.
- done  output  1  one-cycle pulse when HI/LO have just been updated by MULT/DIV.
- dbz  output  1  one-cycle pulse, coincident with done, for a divide by zero.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; hi=0, lo=0, busy=0, done=0, dbz=0.
  - Counter and internal accumulators are cleared.
  - An in-flight operation is discarded.
- State machine:
  - IDLE: no operation in flight.
  - RUN: 32 iteration cycles.
  - FIX: one final cycle for sign correction and HI/LO write.
- IDLE, start=1, op in {001..100}, at edge E:
  - Latch sign flags sa=a[31], sb=b[31] for signed ops, 0 for unsigned ops.
  - Latch magnitudes |a| and |b|; for signed ops this is the two's-complement negate of negative values; 0x80000000 stays 0x80000000 as unsigned.
  - Clear the 64-bit accumulator and set count=0.
  - Go to RUN; busy=1 from E.
- RUN, multiply: one shift-add step per cycle, LSB-first over |b|.
- RUN, divide: one restoring-division step per cycle, MSB-first over |a|; the remainder register is WIDTH+1 bits.
- RUN exit: after 32 RUN edges (E+1..E+32, count wraps 31→0), go to FIX.
- FIX, edge E+33, multiply:
  - If sa^sb, negate the 64-bit product.
  - hi=product[63:32], lo=product[31:0].
- FIX, edge E+33, divide with b≠0:
  - lo=quotient, negated if sa^sb.
  - hi=remainder, negated if sa.
  - -2^31 / -1 gives lo=0x80000000, hi=0 (no trap).
- FIX, edge E+33, divide with b=0: hi and lo unchanged; dbz=1.
- FIX completion:
  - done=1 for the single cycle after E+33.
  - busy=0 from E+33; state=IDLE.
  - Total latency: HI/LO valid 34 cycles after the start edge.
- MTHI/MTLO:
  - In IDLE with start=1 and op=101/110: hi (resp. lo)=a at that edge.
  - busy stays 0 and done is not pulsed.
- start while busy=1: ignored for every op, including MTHI/MTLO; the in-flight operation is unaffected.
- A start in the same cycle done is high is accepted, since the state is IDLE.
- No-op codes (000/111) with start=1: no state change.
- a and b are only sampled at the accepting edge and may change freely afterwards.
- hi and lo are stable (previous values) throughout RUN and FIX until the FIX edge.

Test Plan:
- MULT a=0xFFFFFFFD, b=5 → done at start+34; hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for exactly 33 cycles.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; MULT with the same operands → hi=0, lo=1.
- DIV a=0xFFFFFFF9 (-7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Preload via MTHI 0x1234, MTLO 0x5678 → hi/lo update in 1 cycle with busy=0. Then DIVU a=9, b=0 → dbz and done pulse together; hi=0x1234, lo=0x5678 unchanged.
- Start MULTU 3*4; at cycle +10 assert start with DIV and MTHI → both ignored; final hi=0, lo=12. Back-to-back start in the done cycle is accepted.
- Start MULT, drive reset=0 at cycle +15 (asynchronously, mid-cycle) → hi=lo=0, busy=0 immediately. After release, no done pulse; a new MULT 6*7 gives lo=42.
